// File: rtl/err_compute_seq.sv
// err_compute_seq: steps through NUM_CH IR readings and accumulates a saturating signed weighted line-position error.
// Optional ERR_COMPUTE_FILT_EN averages each new result with the previous one.
module err_compute_seq #(
  parameter int NUM_CH = 8,
  parameter int IR_W = 12,
  parameter int ACC_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          IR_vld,
  input  logic [NUM_CH*IR_W-1:0]        ir_data,
  input  logic [NUM_CH-1:0]             ch_en,
  output logic [$clog2(NUM_CH)-1:0]     sel,
  output logic                          busy,
  output logic signed [ACC_W-1:0]       error,
  output logic                          err_vld,
  output logic                          ovr
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int SW = ACC_W + NUM_CH/2 + 2;
  localparam logic signed [SW-1:0] SMAX = SW'(2**(ACC_W-1) - 1);
  localparam logic signed [SW-1:0] SMIN = -SW'(2**(ACC_W-1));
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nxt;
  logic [NUM_CH*IR_W-1:0] data_q;
  logic [NUM_CH-1:0] en_q;
  logic signed [ACC_W-1:0] acc, sum_sat, err_nxt;
  logic signed [ACC_W:0] avg;
  logic signed [SW-1:0] mag, sum;
  logic [IR_W-1:0] rd;
  logic accept, last;
  assign accept = IR_vld && state != ACCUM;
  assign last = sel == SEL_W'(NUM_CH-1);
  assign busy = state == ACCUM;
  assign err_vld = state == DONE;
  // even channels pull left (+), odd channels pull right (-), weighted by pair index
  always_comb begin
    rd = data_q[sel*IR_W +: IR_W];
    mag = en_q[sel] ? (SW'(rd) <<< (sel >> 1)) : '0;
    sum = sel[0] ? SW'(acc) - mag : SW'(acc) + mag;
    sum_sat = sum > SMAX ? SMAX[ACC_W-1:0] : sum < SMIN ? SMIN[ACC_W-1:0] : sum[ACC_W-1:0];
    avg = {error[ACC_W-1], error} + {sum_sat[ACC_W-1], sum_sat};
`ifdef ERR_COMPUTE_FILT_EN
    err_nxt = avg[ACC_W:1];
`else
    err_nxt = sum_sat;
`endif
    state_nxt = accept ? ACCUM : state == ACCUM ? (last ? DONE : ACCUM) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      acc <= '0;
      error <= '0;
      ovr <= 1'b0;
      data_q <= '0;
      en_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_q <= ir_data;
        en_q <= ch_en;
        acc <= '0;
        sel <= '0;
        ovr <= 1'b0;
      end else if (state == ACCUM) begin
        acc <= sum_sat;
        sel <= last ? sel : sel + 1'b1;
        if (last) error <= err_nxt;
        if (IR_vld) ovr <= 1'b1;
      end
    end
endmodule

// File: tb/tb_err_compute_seq.sv
// tb_err_compute_seq: directed self-checking bench for err_compute_seq at NUM_CH=8, IR_W=12, ACC_W=16.
module tb_err_compute_seq;
  logic clk = 0, rst_n = 0, IR_vld = 0;
  logic [95:0] ir_data = '0;
  logic [7:0] ch_en = '0;
  logic [2:0] sel;
  logic busy, err_vld, ovr;
  logic signed [15:0] error;
  int checks = 0, errors = 0, prev = 0, lat = 0;
  logic [7:0] sel_seen;
  logic vld_seen;

  err_compute_seq #(.NUM_CH(8), .IR_W(12), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .IR_vld(IR_vld), .ir_data(ir_data), .ch_en(ch_en),
    .sel(sel), .busy(busy), .error(error), .err_vld(err_vld), .ovr(ovr));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int expect_err(input int raw);
`ifdef ERR_COMPUTE_FILT_EN
    prev = (prev + raw) >>> 1;
`else
    prev = raw;
`endif
    return prev;
  endfunction

  function automatic logic [95:0] one(input int ch, input logic [11:0] v);
    logic [95:0] d = '0;
    d[ch*12 +: 12] = v;
    return d;
  endfunction

  // call at a negedge; returns at the negedge of the err_vld cycle (cycle index in lat)
  task automatic run(input logic [95:0] d, input logic [7:0] en, input int ovr_at, output int n);
    ir_data = d;
    ch_en = en;
    IR_vld = 1;
    sel_seen = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      IR_vld = (n == ovr_at);
      if (n == ovr_at) ir_data = ~d;
      if (busy) sel_seen[sel] = 1'b1;
    end while (!err_vld && n < 40);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_err_vld", int'(err_vld), 0);
    check("rst_error", int'(error), 0);
    check("rst_ovr", int'(ovr), 0);
    check("rst_sel", int'(sel), 0);

    run({8{12'h100}}, 8'hFF, 0, lat);
    check("sym_latency", lat, 9);
    check("sym_error", int'(error), expect_err(0));
    check("sym_sel_steps", int'(sel_seen), 8'hFF);
    @(negedge clk);
    check("sym_vld_one_cycle", int'(err_vld), 0);
    check("sym_sel_hold", int'(sel), 7);

    run(one(6, 12'h100), 8'hFF, 0, lat);
    check("left_error1", int'(error), expect_err(2048));
    run(one(6, 12'h100), 8'hFF, 0, lat);
    check("b2b_latency", lat, 9);
    check("left_error2", int'(error), expect_err(2048));

    run(one(7, 12'hFFF) | one(5, 12'hFFF), 8'hFF, 0, lat);
    check("sat_error", int'(error), expect_err(-32768));
    run({8{12'h100}}, 8'h55, 0, lat);
    check("mask_latency", lat, 9);
    check("mask_error", int'(error), expect_err(3840));

    run(one(6, 12'h100), 8'hFF, 3, lat);
    check("ovr_latency", lat, 9);
    check("ovr_set", int'(ovr), 1);
    check("ovr_error", int'(error), expect_err(2048));
    run(one(1, 12'h010), 8'hFF, 0, lat);
    check("ovr_cleared", int'(ovr), 0);
    check("ovr_next_error", int'(error), expect_err(-16));

    run(one(0, 12'h200), 8'hFF, 0, lat);
    check("pre_rst_error", int'(error), expect_err(512));
    @(negedge clk);
    ir_data = {8{12'hABC}};
    ch_en = 8'hFF;
    IR_vld = 1;
    @(negedge clk);
    IR_vld = 0;
    repeat (3) @(negedge clk);
    check("mid_busy_before", int'(busy), 1);
    rst_n = 0;
    #1;
    prev = 0;
    check("mid_busy", int'(busy), 0);
    check("mid_error", int'(error), 0);
    check("mid_err_vld", int'(err_vld), 0);
    @(negedge clk);
    rst_n = 1;
    vld_seen = 0;
    repeat (12) begin
      @(negedge clk);
      vld_seen |= err_vld;
    end
    check("mid_no_vld", int'(vld_seen), 0);
    run(one(2, 12'h100) | one(3, 12'h040), 8'hFF, 0, lat);
    check("post_rst_latency", lat, 9);
    check("post_rst_error", int'(error), expect_err(384));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
